// File: rtl/sipo_pkg.sv
// sipo_pkg -- shared constants for the serial-in/parallel-out deserializer.
//   SIPO_DEF_WIDTH : default frame width in bits.
//   sipo_cnt_w()   : width of a counter able to represent 0..width.
package sipo_pkg;

    localparam int SIPO_DEF_WIDTH = 8;

    function automatic int sipo_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// sipo_shift_core -- direction-selectable serial shift register.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset (register -> 0)
//   clear_i    : synchronous clear (register -> 0), wins over shift_en_i
//   shift_en_i : accept si_i this cycle
//   si_i       : serial data bit
//   frame_o    : register contents with si_i already shifted in, so the
//                parent can capture a complete frame on the final bit edge
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_DEF_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             shift_en_i,
    input  logic             si_i,
    output logic [WIDTH-1:0] frame_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        // MSB-first shifts left so the oldest bit ends at the top;
        // LSB-first shifts right so the oldest bit ends at bit 0.
        if (MSB_FIRST != 0) begin
            shifted = {sr_q[WIDTH-2:0], si_i};
        end else begin
            shifted = {si_i, sr_q[WIDTH-1:1]};
        end

        sr_d = sr_q;
        if (clear_i) begin
            sr_d = '0;
        end else if (shift_en_i) begin
            sr_d = shifted;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign frame_o = shifted;

endmodule

// File: rtl/sipo_deser.sv
// sipo_deser -- serial-in/parallel-out deserializer with a one-deep output
// register, valid/ready handshake and sticky overrun flag.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-high reset
//   si       : serial data bit, sampled when si_valid=1
//   si_valid : serial bit strobe
//   clear    : synchronous frame restart (shift reg, bit_cnt, overrun)
//   po       : last completed frame (registered)
//   po_valid : po holds an unconsumed frame
//   po_ready : consumer accepts po when po_valid=1
//   bit_cnt  : bits collected in the current frame, 0..WIDTH-1
//   overrun  : sticky, set when a completed frame had to be dropped
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_DEF_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          si,
    input  logic                          si_valid,
    input  logic                          clear,
    output logic [WIDTH-1:0]              po,
    output logic                          po_valid,
    input  logic                          po_ready,
    output logic [sipo_cnt_w(WIDTH)-1:0]  bit_cnt,
    output logic                          overrun
);

    localparam int CNT_W = sipo_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] frame;
    logic [WIDTH-1:0] po_q, po_d;
    logic             po_valid_q, po_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overrun_q, overrun_d;
    logic             complete;
    logic             handshake;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk        (clk),
        .rst        (reset),
        .clear_i    (clear),
        .shift_en_i (si_valid),
        .si_i       (si),
        .frame_o    (frame)
    );

    always_comb begin
        // clear drops this cycle's bit, so it can never complete a frame.
        complete  = si_valid && !clear && (cnt_q == LAST_BIT);
        handshake = po_valid_q && po_ready;

        cnt_d      = cnt_q;
        po_d       = po_q;
        po_valid_d = po_valid_q;
        overrun_d  = overrun_q;

        if (clear) begin
            cnt_d = '0;
        end else if (si_valid) begin
            cnt_d = complete ? '0 : cnt_q + CNT_W'(1);
        end

        if (complete) begin
            // Output slot is free if empty or being consumed this cycle;
            // otherwise the new frame is lost and that is recorded.
            if (!po_valid_q || po_ready) begin
                po_d       = frame;
                po_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (handshake) begin
            po_valid_d = 1'b0;
        end

        if (clear) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            po_q       <= '0;
            po_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            po_q       <= po_d;
            po_valid_q <= po_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign po       = po_q;
    assign po_valid = po_valid_q;
    assign bit_cnt  = cnt_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
module tb_sipo_deser;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          si;
    logic          si_valid;
    logic          clear;
    logic          po_ready;
    logic [W-1:0]  po_m, po_l;
    logic          pv_m, pv_l;
    logic [CW-1:0] cnt_m, cnt_l;
    logic          ovr_m, ovr_l;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .reset(reset), .si(si), .si_valid(si_valid), .clear(clear),
        .po(po_m), .po_valid(pv_m), .po_ready(po_ready), .bit_cnt(cnt_m),
        .overrun(ovr_m)
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(reset), .si(si), .si_valid(si_valid), .clear(clear),
        .po(po_l), .po_valid(pv_l), .po_ready(po_ready), .bit_cnt(cnt_l),
        .overrun(ovr_l)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: bits are stored by arrival index (acc[k] = k-th
    // bit of the frame). A completed frame is that vector as-is for
    // LSB-first and bit-reversed for MSB-first.
    logic [W-1:0] m_acc;
    int           m_n;
    logic [W-1:0] m_po_m, m_po_l;
    logic         m_pv, m_ovr;
    logic         m_done;
    logic [W-1:0] m_full;

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int k = 0; k < W; k++) r[W-1-k] = v[k];
        return r;
    endfunction

    assign m_done = si_valid && !clear && (m_n == W - 1);
    assign m_full = {si, m_acc[W-2:0]};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_acc  <= '0;
            m_n    <= 0;
            m_po_m <= '0;
            m_po_l <= '0;
            m_pv   <= 1'b0;
            m_ovr  <= 1'b0;
        end else begin
            if (clear) begin
                m_n   <= 0;
                m_ovr <= 1'b0;
            end else if (si_valid) begin
                m_acc[m_n] <= si;
                m_n        <= m_done ? 0 : m_n + 1;
            end
            if (m_done) begin
                if (!m_pv || po_ready) begin
                    m_po_m <= rev(m_full);
                    m_po_l <= m_full;
                    m_pv   <= 1'b1;
                end else begin
                    m_ovr <= 1'b1;
                end
            end else if (m_pv && po_ready) begin
                m_pv <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("po_msb",  32'(po_m),  32'(m_po_m));
            chk("po_lsb",  32'(po_l),  32'(m_po_l));
            chk("pv_msb",  32'(pv_m),  32'(m_pv));
            chk("pv_lsb",  32'(pv_l),  32'(m_pv));
            chk("cnt_msb", 32'(cnt_m), 32'(m_n));
            chk("cnt_lsb", 32'(cnt_l), 32'(m_n));
            chk("ovr_msb", 32'(ovr_m), 32'(m_ovr));
            chk("ovr_lsb", 32'(ovr_l), 32'(m_ovr));
        end
    end

    task automatic cyc(input logic v, input logic b, input logic r, input logic c);
        si_valid = v;
        si       = b;
        po_ready = r;
        clear    = c;
        @(negedge clk);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_po_m"}, 32'(po_m), 0);
        chk({nm, "_po_l"}, 32'(po_l), 0);
        chk({nm, "_pv"},   32'(pv_m | pv_l), 0);
        chk({nm, "_cnt"},  32'(cnt_m | cnt_l), 0);
        chk({nm, "_ovr"},  32'(ovr_m | ovr_l), 0);
    endtask

    initial begin
        reset = 1'b1; si = 1'b0; si_valid = 1'b0; clear = 1'b0; po_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_zero("rst");
        chk_en = 1'b1;

        // Frame 1,0,1,1 with consumer ready
        cyc(1, 1, 1, 0); cyc(1, 0, 1, 0); cyc(1, 1, 1, 0); cyc(1, 1, 1, 0);
        chk("f1_po_m", 32'(po_m), 32'hB);
        chk("f1_po_l", 32'(po_l), 32'hD);
        chk("f1_pv",   32'(pv_m), 1);
        cyc(0, 0, 1, 0);
        chk("f1_pv_drop", 32'(pv_m), 0);
        chk("f1_po_hold", 32'(po_m), 32'hB);

        // Two frames without consumer: second one is an overrun
        cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 0, 0, 0);
        chk("ovr_po",  32'(po_m), 32'hB);
        chk("ovr_pv",  32'(pv_m), 1);
        chk("ovr_set", 32'(ovr_m), 1);
        cyc(0, 0, 0, 1);
        chk("clr_ovr", 32'(ovr_m), 0);
        chk("clr_po",  32'(po_m), 32'hB);
        chk("clr_pv",  32'(pv_m), 1);

        // Handshake coincident with last bit of the next frame
        cyc(1, 0, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 0, 1, 0);
        chk("hs_po_m", 32'(po_m), 32'h6);
        chk("hs_po_l", 32'(po_l), 32'h6);
        chk("hs_pv",   32'(pv_m), 1);
        chk("hs_ovr",  32'(ovr_m), 0);

        // Reset between edges after 2 of 4 bits
        cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
        chk("mid_cnt", 32'(cnt_m), 2);
        si_valid = 1'b0;
        #2 reset = 1'b1;
        #1 chk_zero("async");
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 0, 1, 0); cyc(1, 0, 1, 0); cyc(1, 1, 1, 0); cyc(1, 1, 1, 0);
        chk("pr_po_m", 32'(po_m), 32'h3);
        chk("pr_po_l", 32'(po_l), 32'hC);

        // clear + si_valid together drops the bit
        cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
        chk("cs_cnt2", 32'(cnt_m), 2);
        cyc(1, 1, 0, 1);
        chk("cs_cnt0", 32'(cnt_m), 0);
        chk("cs_po",   32'(po_m), 32'h3);

        // Strobe every third cycle
        for (int i = 0; i < 24; i++) begin
            cyc(1, 1'($urandom_range(0, 1)), 1, 0);
            cyc(0, 1'($urandom_range(0, 1)), 1, 0);
            cyc(0, 1'($urandom_range(0, 1)), 1, 0);
        end

        // Randomised traffic with varying density, backpressure and clears
        for (int i = 0; i < 4000; i++) begin
            int seg;
            logic v, r, c;
            seg = (i / 250) % 4;
            case (seg)
                0:       v = 1'b1;
                1:       v = ((i % 3) == 0);
                2:       v = ($urandom_range(0, 3) != 0);
                default: v = ($urandom_range(0, 1) != 0);
            endcase
            r = (seg == 2) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 40) == 0);
            if ((i % 700) == 350) begin
                si_valid = 1'b0;
                clear    = 1'b0;
                #2 reset = 1'b1;
                #1 @(negedge clk);
                reset = 1'b0;
            end
            cyc(v, 1'($urandom_range(0, 1)), r, c);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 8, number of serial bits per frame; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 means the first received bit lands in po[WIDTH-1]; 0 means the first received bit lands in po[0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 si  input  1  serial data bit.
REQ-006 si_valid  input  1  bit strobe; si is sampled only in cycles where si_valid=1.
REQ-007 clear  input  1  synchronous frame restart.
REQ-008 po  output  WIDTH  assembled parallel frame (registered).
REQ-009 po_valid  output  1  po holds an unconsumed frame.
REQ-010 po_ready  input  1  consumer accepts po when po_valid=1 and po_ready=1.
REQ-011 bit_cnt  output  $clog2(WIDTH+1)  bits collected in the current frame, 0..WIDTH-1 (registered).
REQ-012 overrun  output  1  sticky flag: a completed frame was dropped.

Function
REQ-013 On si_valid=1 with MSB_FIRST=1, the shift register shall shift left, with si entering bit 0.
REQ-014 On si_valid=1 with MSB_FIRST=0, the shift register shall shift right, with si entering bit WIDTH-1.
REQ-015 si_valid=0 shall hold the shift register and bit_cnt unchanged.
REQ-016 bit_cnt shall increment on each accepted bit; it shall wrap to 0 on the bit that makes the count reach WIDTH.
REQ-017 Frame completion is the cycle where si_valid=1 and bit_cnt=WIDTH-1.
REQ-018 On completion, po shall be loaded with the full frame, including the current bit, on that same clock edge.
REQ-019 po_valid shall rise on that same edge, giving 1-cycle latency from the final bit strobe.
REQ-020 po and po_valid shall hold until a handshake (po_valid & po_ready); on the handshake edge, po_valid shall clear unless a new frame completes in the same cycle.
REQ-021 If a handshake and a completion occur in the same cycle, the new frame shall load, po_valid shall remain 1, and overrun shall be unchanged.
REQ-022 If a completion occurs while po_valid=1 with no handshake, the new frame shall be discarded, po shall keep the old frame, and overrun shall be set to 1.
REQ-023 overrun shall stay at 1 until clear or reset.
REQ-024 clear=1 shall zero the shift register, bit_cnt and overrun; it shall leave po and po_valid unaffected.
REQ-025 clear shall have priority over si_valid in the same cycle; that cycle's bit shall be dropped.
REQ-026 po_ready shall be ignored while po_valid=0.

Reset
REQ-027 reset=1 shall immediately set the shift register, po, bit_cnt, po_valid and overrun to 0, independent of clk.
REQ-028 Reset asserted mid-frame shall discard any partial frame; the first si_valid after release shall be bit 0 of a new frame.
REQ-029 After reset release, no output shall change until an si_valid, clear or handshake event occurs.

Structure
REQ-030 Package sipo_pkg shall hold SIPO_DEF_WIDTH=8 and the counter-width constant/function based on $clog2.
REQ-031 One sub-module, sipo_shift_core, shall contain the direction-selectable shift register, with parameters WIDTH and MSB_FIRST.
REQ-032 The handshake, counter and overrun logic shall reside in sipo_deser.

Verification
REQ-033 WIDTH=4, MSB_FIRST=1, bits 1,0,1,1 on consecutive strobes with po_ready=1 -> po=4'b1011 and po_valid=1 for one cycle, 1 cycle after the 4th strobe.
REQ-034 WIDTH=4, MSB_FIRST=0, same bits -> po=4'b1101.
REQ-035 po_ready=0, two frames 1011 then 0110 -> po stays 1011, po_valid=1, overrun=1; a subsequent clear -> overrun=0 and po still 1011.
REQ-036 Handshake coincident with the 2nd frame's last bit -> po=0110, po_valid stays 1, overrun=0.
REQ-037 Reset asserted between clock edges after 2 of 4 bits -> all outputs 0 immediately; a fresh 4-bit frame 0011 -> po=4'b0011.
REQ-038 si_valid gaps (strobe every 3rd cycle) and clear+si_valid in the same cycle -> bit dropped and bit_cnt=0; bit_cnt never exceeds WIDTH-1.
